pll_lock_ctrl: RTL and testbench

//  Reset/lock controller for the clocking PLL wrapper: drives the PLL RST input and consumes its LOCK output.

---
 rtl/pll_lock_ctrl.sv | 122 ++++++++++++
 tb/tb_pll_lock_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock,
// and releases a registered system reset once lock has been stable; counts lock losses in RUN.
module pll_lock_ctrl #(
    parameter int RST_HOLD      = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int LOCK_FILTER   = 1024,
    parameter int POST_LOCK_DLY = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             locked_stable,
    output logic             timeout_err,
    output logic [CNT_W-1:0] relock_cnt
);

    localparam int MAX_AB  = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int MAX_CD  = (LOCK_FILTER > POST_LOCK_DLY) ? LOCK_FILTER : POST_LOCK_DLY;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [TMR_W-1:0] HOLD_END    = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_END = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FILTER_END  = TMR_W'(LOCK_FILTER - 1);
    localparam logic [TMR_W-1:0] DELAY_END   = TMR_W'(POST_LOCK_DLY - 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        FILTER,
        DELAY,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             lock_p0;
    logic             lock_s;
    logic             timeout_nxt;
    logic             loss_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_s  <= lock_p0;
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_nxt = 1'b0;
        loss_inc    = 1'b0;
        case (state)
            RESET_PLL: if (timer == HOLD_END) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                // A lock seen on the last timeout cycle still wins over the timeout
                if (lock_s) begin
                    state_nxt = FILTER;
                end else if (timer == TIMEOUT_END) begin
                    state_nxt   = RESET_PLL;
                    timeout_nxt = 1'b1;
                end
            end
            FILTER: begin
                if (!lock_s)                  state_nxt = WAIT_LOCK;
                else if (timer == FILTER_END) state_nxt = DELAY;
            end
            DELAY: begin
                if (!lock_s)                 state_nxt = RESET_PLL;
                else if (timer == DELAY_END) state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = RESET_PLL;
                    loss_inc  = 1'b1;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_PLL;
            timer         <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            locked_stable <= 1'b0;
            timeout_err   <= 1'b0;
            relock_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (state != RUN)
                timer <= timer + 1'b1;
            pll_rst       <= (state_nxt == RESET_PLL);
            sys_rst_n     <= (state_nxt == RUN);
            locked_stable <= (state_nxt == RUN);
            timeout_err   <= timeout_nxt;
            if (clr_cnt)
                relock_cnt <= '0;
            else if (loss_inc)
                relock_cnt <= sat_inc(relock_cnt);
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters; inputs change and
// outputs are sampled on the falling clock edge, cycle numbers count rising edges after release.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked_stable;
    logic       timeout_err;
    logic [1:0] relock_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_ctrl #(
        .RST_HOLD(4), .LOCK_TIMEOUT(32), .LOCK_FILTER(8), .POST_LOCK_DLY(4), .CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clr_cnt(clr_cnt),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .locked_stable(locked_stable),
        .timeout_err(timeout_err), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b exp 1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %b exp 0", sys_rst_n); end
        checks++; if (locked_stable !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked_stable); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
        checks++; if (relock_cnt !== 2'd0) begin errors++; $display("FAIL reset_relock_cnt got %0d exp 0", relock_cnt); end
        rst_n = 1'b1;
    endtask

    // Lock rises after cycle 10: sync 2 + filter 8 + delay 4 + entry 1 -> RUN at cycle 25
    task automatic test_lock_up();
        logic exp_rst, exp_run;
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_rst = (i < 4);
            exp_run = (i >= 25);
            checks++; if (pll_rst !== exp_rst) begin errors++; $display("FAIL t1_pll_rst cyc %0d got %b exp %b", i, pll_rst, exp_rst); end
            checks++; if (sys_rst_n !== exp_run) begin errors++; $display("FAIL t1_sys_rst_n cyc %0d got %b exp %b", i, sys_rst_n, exp_run); end
            checks++; if (locked_stable !== exp_run) begin errors++; $display("FAIL t1_locked cyc %0d got %b exp %b", i, locked_stable, exp_run); end
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t1_timeout cyc %0d got %b exp 0", i, timeout_err); end
            if (i == 10) pll_lock = 1'b1;
        end
    endtask

    // No lock: 32 WAIT cycles then pulse + 4 RESET cycles, period 36
    task automatic test_timeout();
        logic exp_rst, exp_to;
        int pulses = 0;
        apply_reset();
        for (int i = 1; i <= 110; i++) begin
            tick();
            exp_rst = ((i % 36) < 4);
            exp_to  = ((i % 36) == 0);
            if (timeout_err === 1'b1) pulses++;
            checks++; if (pll_rst !== exp_rst) begin errors++; $display("FAIL t2_pll_rst cyc %0d got %b exp %b", i, pll_rst, exp_rst); end
            checks++; if (timeout_err !== exp_to) begin errors++; $display("FAIL t2_timeout cyc %0d got %b exp %b", i, timeout_err, exp_to); end
            checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t2_sys_rst_n cyc %0d got %b exp 0", i, sys_rst_n); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL t2_pulse_count got %0d exp 3", pulses); end
    endtask

    // Lock high for 5 cycles drops inside FILTER, returns at cycle 20 -> RUN at 35
    task automatic test_filter_drop();
        logic exp_run;
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_run = (i >= 35);
            checks++; if (sys_rst_n !== exp_run) begin errors++; $display("FAIL t3_sys_rst_n cyc %0d got %b exp %b", i, sys_rst_n, exp_run); end
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t3_timeout cyc %0d got %b exp 0", i, timeout_err); end
            checks++; if (pll_rst !== (i < 4)) begin errors++; $display("FAIL t3_pll_rst cyc %0d got %b exp %b", i, pll_rst, (i < 4)); end
            if (i == 10) pll_lock = 1'b1;
            if (i == 15) pll_lock = 1'b0;
            if (i == 20) pll_lock = 1'b1;
        end
    endtask

    // Loss at F: sys_rst_n falls at F+3; relock restored at F+20
    task automatic test_relock_sat();
        logic [1:0] exp_cnt;
        apply_reset();
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 10) pll_lock = 1'b1;
        end
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL t4_initial_run got %b exp 1", sys_rst_n); end
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
            pll_lock = 1'b0;
            tick(); tick();
            checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL t4_sys_early loss %0d got %b exp 1", k, sys_rst_n); end
            tick();
            checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t4_sys_fall loss %0d got %b exp 0", k, sys_rst_n); end
            checks++; if (locked_stable !== 1'b0) begin errors++; $display("FAIL t4_locked_fall loss %0d got %b exp 0", k, locked_stable); end
            checks++; if (relock_cnt !== exp_cnt) begin errors++; $display("FAIL t4_relock_cnt loss %0d got %0d exp %0d", k, relock_cnt, exp_cnt); end
            pll_lock = 1'b1;
            repeat (16) tick();
            checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t4_sys_pre_run loss %0d got %b exp 0", k, sys_rst_n); end
            tick();
            checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL t4_sys_rerun loss %0d got %b exp 1", k, sys_rst_n); end
            checks++; if (locked_stable !== 1'b1) begin errors++; $display("FAIL t4_locked_rerun loss %0d got %b exp 1", k, locked_stable); end
            repeat (3) tick();
        end
    endtask

    // Continues in RUN with relock_cnt=3; finishes with the FSM parked in DELAY
    task automatic test_clr_on_loss();
        pll_lock = 1'b0;
        tick(); tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (relock_cnt !== 2'd0) begin errors++; $display("FAIL t5_clr_wins got %0d exp 0", relock_cnt); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t5_sys_fall got %b exp 0", sys_rst_n); end
        pll_lock = 1'b1;
        repeat (17) tick();
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL t5_rerun got %b exp 1", sys_rst_n); end
        repeat (3) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        checks++; if (relock_cnt !== 2'd1) begin errors++; $display("FAIL t5_count_after_clr got %0d exp 1", relock_cnt); end
        pll_lock = 1'b1;
        repeat (14) tick();
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t5_in_delay got %b exp 0", sys_rst_n); end
    endtask

    task automatic test_async_reset();
        logic exp_run;
        rst_n = 1'b0;
        #1;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL t6_async_pll_rst got %b exp 1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t6_async_sys_rst_n got %b exp 0", sys_rst_n); end
        checks++; if (locked_stable !== 1'b0) begin errors++; $display("FAIL t6_async_locked got %b exp 0", locked_stable); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t6_async_timeout got %b exp 0", timeout_err); end
        checks++; if (relock_cnt !== 2'd0) begin errors++; $display("FAIL t6_async_relock_cnt got %0d exp 0", relock_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Lock already high: synchroniser refills during RESET_PLL, RUN at cycle 17
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_run = (i >= 17);
            checks++; if (pll_rst !== (i < 4)) begin errors++; $display("FAIL t6_pll_rst cyc %0d got %b exp %b", i, pll_rst, (i < 4)); end
            checks++; if (sys_rst_n !== exp_run) begin errors++; $display("FAIL t6_sys_rst_n cyc %0d got %b exp %b", i, sys_rst_n, exp_run); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_up();
        test_timeout();
        test_filter_drop();
        test_relock_sat();
        test_clr_on_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
